// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_pkg
// Description : Shared types and sizing constants for the sequential
//               binary-to-BCD (double-dabble) converter.
//               Contents:
//                 state_t                  - FSM state enum (IDLE, CONVERT)
//                 BIN_W / BCD_DIGITS       - operand and accumulator sizing
//                 DISP_DIGITS              - digits presented on the outputs
//                 ITERATIONS / LAST_STEP   - double-dabble step count
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int unsigned BIN_W       = 32;
  localparam int unsigned BCD_DIGITS  = 10;
  localparam int unsigned DISP_DIGITS = 4;
  localparam int unsigned ITERATIONS  = 32;

  localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
  localparam int unsigned DISP_W = 4 * DISP_DIGITS;
  localparam int unsigned CNT_W  = 6;

  // Counter value during the final shift step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble add-3 correction for one BCD nibble.
//               Purely combinational.
//               Ports:
//                 digit_i [3:0] - accumulator nibble before the shift
//                 digit_o [3:0] - nibble + 3 when >= 5, else unchanged
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A nibble >= 5 would become >= 10 after the left shift, so pre-add 3
  // to force the carry into the next decimal digit.
  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential 32-bit binary to BCD converter using one
//               double-dabble step per clock. Presents the low four
//               decimal digits and flags values above 9999.
//               Ports:
//                 clk       - rising-edge clock
//                 reset     - synchronous active-high reset
//                 start     - conversion request, accepted only in IDLE
//                 value     - 32-bit unsigned operand, captured on accept
//                 busy      - high while converting
//                 done      - one-cycle pulse, new results valid
//                 digit0..3 - BCD ones, tens, hundreds, thousands
//                 overflow  - captured value exceeded 9999
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic             overflow
);

  state_t            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [BCD_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DISP_W-1:0] disp_q;
  logic              overflow_q;

  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_d;
  logic [BIN_W-1:0]  shift_d;
  logic              acc_carry_unused;

  // One add-3 corrector per accumulator nibble.
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*i +: 4]),
      .digit_o (acc_adj[4*i +: 4])
    );
  end

  // Shift {corrected accumulator, shift register} left by one. The bit
  // leaving the top of the accumulator is always zero for a 32-bit operand
  // in a 10-digit accumulator, so it is dropped.
  assign {acc_carry_unused, acc_d} = {acc_adj, shift_q[BIN_W-1]};
  assign shift_d = {shift_q[BIN_W-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          shift_q <= shift_d;
          acc_q   <= acc_d;
          if (cnt_q == LAST_STEP) begin
            // Final step: publish from the freshly shifted accumulator
            // on this same edge.
            disp_q     <= acc_d[DISP_W-1:0];
            overflow_q <= |acc_d[BCD_W-1:DISP_W];
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digit0   = disp_q[3:0];
  assign digit1   = disp_q[7:4];
  assign digit2   = disp_q[11:8];
  assign digit3   = disp_q[15:12];
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. Expected digits come
//               from decimal arithmetic on the operand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        overflow;

  int n_tests;
  int n_fail;
  logic [16:0] last_pack;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {thousands, hundreds, tens, ones, overflow}
  function automatic logic [16:0] model(input logic [31:0] v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10),
            4'(v % 10), (v > 32'd9999)};
  endfunction

  function automatic logic [16:0] dut_pack();
    return {digit3, digit2, digit1, digit0, overflow};
  endfunction

  // Full conversion: accept, check hold/busy, wait for done, check result.
  task automatic run_conv(input logic [31:0] v, input string tag);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = $urandom;
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'(dut_pack()), 32'(last_pack));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, k, 32'd32);
        break;
      end
      if (k < 32) begin
        if (busy !== 1'b1) check({tag, "_busy_mid"}, 32'(busy), 32'd1);
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(dut_pack()), 32'(model(v)));
    last_pack = model(v);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int q_edges[$];
    logic [31:0] rv;

    n_tests   = 0;
    n_fail    = 0;
    last_pack = '0;
    reset     = 1'b1;
    start     = 1'b1;   // must not be accepted while reset is high
    value     = 32'd5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'(dut_pack()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;

    // Directed values
    run_conv(32'd0,          "v0");
    run_conv(32'd9999,       "v9999");
    run_conv(32'd10000,      "v10000");
    run_conv(32'hFFFF_FFFF,  "vmax");
    check("vmax_digits", 32'(dut_pack()), 32'({4'd7, 4'd2, 4'd9, 4'd5, 1'b1}));
    run_conv(32'd1234,       "v1234");

    // start/value changes during CONVERT are ignored
    @(negedge clk);
    start = 1'b1;
    value = 32'd1234;
    @(posedge clk);
    #1;
    start    = 1'b0;
    value    = 32'd5678;
    done_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 10);
      value = (k == 10) ? 32'd5678 : $urandom;
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        done_at = k;
        check("ign_result", 32'(dut_pack()), 32'(model(32'd1234)));
      end
    end
    check("ign_done_cnt", done_cnt, 32'd1);
    check("ign_done_at", done_at, 32'd32);
    last_pack = model(32'd1234);

    // Reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    value = 32'd4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outs", 32'(dut_pack()), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_hold", 32'(dut_pack()), 32'd0);
    last_pack = '0;
    run_conv(32'd42, "v42");

    // start held high: back-to-back conversions every 33 cycles
    @(negedge clk);
    start = 1'b1;
    value = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        q_edges.push_back(k);
        check("hold_digit0", 32'(digit0), 32'd7);
      end
    end
    check("hold_n_done", q_edges.size(), 32'd3);
    if (q_edges.size() == 3) begin
      check("hold_edge0", q_edges[0], 32'd32);
      check("hold_edge1", q_edges[1], 32'd65);
      check("hold_edge2", q_edges[2], 32'd98);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    last_pack = '0;

    // Randomized operands
    for (int i = 0; i < 16; i++) begin
      rv = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20000));
      run_conv(rv, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
